pipreg_skid_stage: RTL and testbench

Parametrised, handshaked pipeline register for the core's inter-stage boundaries (EXE/MEM and later). It generalises the fixed-field stall-hold register into a generic payload stage with valid/ready flow control, a two-entry skid buffer for a fully registered `in_ready`, synchronous flush, and a one-shot strobe field for side-effecting requests such as cache enable/write. It sits between two pipeline stages and carries an opaque payload plus strobe bits.

---
 rtl/pipreg_pkg.sv | 39 +++
 rtl/pipreg_skid_stage.sv | 125 ++++++++++++
 tb/tb_pipreg_skid_stage.sv | 208 ++++++++++++++++++++
 3 files changed

// File: rtl/pipreg_pkg.sv
// Shared definitions for the handshaked pipeline register stages.
// Contents:
//   pipreg_state_e     - occupancy state of a two-entry skid stage
//   PIPREG_ENTRY_T     - macro building a packed {data, stb} entry of any width
//   exe_mem_payload_t  - EXE/MEM payload packed into in_data (64 bits)
//   exe_mem_stb_t      - EXE/MEM one-shot strobes packed into in_stb (2 bits)
//   pipreg_occupancy() - state to entry count (0..2)

`ifndef PIPREG_ENTRY_T
`define PIPREG_ENTRY_T(DW, SW) struct packed { logic [(DW)-1:0] data; logic [(SW)-1:0] stb; }
`endif

package pipreg_pkg;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      FULL  = 2'd2
   } pipreg_state_e;

   typedef struct packed {
      logic [31:0] alu_result;
      logic [31:0] store_data;
   } exe_mem_payload_t;

   typedef struct packed {
      logic dcache_write;
      logic dcache_en;
   } exe_mem_stb_t;

   function automatic logic [1:0] pipreg_occupancy(input pipreg_state_e s);
      case (s)
         ONE:     return 2'd1;
         FULL:    return 2'd2;
         default: return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/pipreg_skid_stage.sv
// Generic valid/ready pipeline register with a two-entry skid buffer,
// synchronous flush, global stall and one-shot strobes.
// Ports:
//   clk, rst            rising-edge clock, synchronous active-high reset
//   stall, flush        global freeze / kill all held entries
//   in_valid/in_ready   upstream handshake, in_data/in_stb payload
//   out_valid/out_ready downstream handshake, out_data/out_stb head entry
//   occupancy           held entries 0..2
//   stall_cnt           saturating count of stalled cycles
//
// state | meaning
// EMPTY | no entry held
// ONE   | main entry M holds the head
// FULL  | M holds the head, skid entry S holds the next payload

module pipreg_skid_stage
   import pipreg_pkg::*;
#(
   parameter int DATA_W = 64,
   parameter int STB_W  = 2,
   parameter int CNT_W  = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [STB_W-1:0]  in_stb,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic [STB_W-1:0]  out_stb,
   output logic [1:0]        occupancy,
   output logic [CNT_W-1:0]  stall_cnt
);

   typedef `PIPREG_ENTRY_T(DATA_W, STB_W) entry_t;

   pipreg_state_e state, state_nxt;
   entry_t        m_ent, s_ent;
   logic          m_pending;
   logic          accept, deliver;
   logic          load_m_in, load_s_in, move_s_m;

   // in_ready depends only on registered state and the global controls,
   // never on out_ready.
   assign in_ready  = !rst && !stall && (state != FULL);
   assign out_valid = (state != EMPTY) && !stall;
   assign accept    = in_valid && in_ready;
   assign deliver   = out_valid && out_ready;

   always_comb begin
      state_nxt = state;
      load_m_in = 1'b0;
      load_s_in = 1'b0;
      move_s_m  = 1'b0;
      if (flush) begin
         state_nxt = EMPTY;
      end else begin
         case (state)
            EMPTY: begin
               if (accept) begin
                  load_m_in = 1'b1;
                  state_nxt = ONE;
               end
            end
            ONE: begin
               if (accept && deliver) begin
                  load_m_in = 1'b1;
               end else if (accept) begin
                  load_s_in = 1'b1;
                  state_nxt = FULL;
               end else if (deliver) begin
                  state_nxt = EMPTY;
               end
            end
            FULL: begin
               if (deliver) begin
                  move_s_m  = 1'b1;
                  state_nxt = ONE;
               end
            end
            default: state_nxt = EMPTY;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= EMPTY;
         m_pending <= 1'b0;
         stall_cnt <= '0;
      end else begin
         state     <= state_nxt;
         // Pending lives for exactly the first cycle an entry is the head.
         m_pending <= load_m_in || move_s_m;
         if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
         end
      end
   end

   // Payload registers carry no reset; validity is tracked by state alone.
   always_ff @(posedge clk) begin
      if (load_m_in) begin
         m_ent.data <= in_data;
         m_ent.stb  <= in_stb;
      end else if (move_s_m) begin
         m_ent <= s_ent;
      end
      if (load_s_in) begin
         s_ent.data <= in_data;
         s_ent.stb  <= in_stb;
      end
   end

   // Masking with state gives a clean 0 on out_data after reset or flush
   // even though the data register itself is never cleared.
   assign out_data  = (state != EMPTY) ? m_ent.data : '0;
   assign out_stb   = ((state != EMPTY) && m_pending) ? m_ent.stb : '0;
   assign occupancy = pipreg_occupancy(state);

endmodule

// File: tb/tb_pipreg_skid_stage.sv
module tb_pipreg_skid_stage;

   localparam int DATA_W = 16;
   localparam int STB_W  = 2;
   localparam int CNT_W  = 4;

   logic              clk = 1'b0;
   logic              rst, stall, flush, in_valid, in_ready, out_valid, out_ready;
   logic [DATA_W-1:0] in_data, out_data;
   logic [STB_W-1:0]  in_stb, out_stb;
   logic [1:0]        occupancy;
   logic [CNT_W-1:0]  stall_cnt;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   pipreg_skid_stage #(.DATA_W(DATA_W), .STB_W(STB_W), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_stb(in_stb),
      .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_stb(out_stb),
      .occupancy(occupancy), .stall_cnt(stall_cnt)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; stall = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_data = '0; in_stb = '0;
      tick();
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rst_in_ready: got %0h expected 0", in_ready); end
      tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_out_valid: got %0h expected 0", out_valid); end
      n_cmp++; if (out_data !== 16'h0) begin n_err++; $display("FAIL rst_out_data: got %0h expected 0", out_data); end
      n_cmp++; if (out_stb !== 2'b00) begin n_err++; $display("FAIL rst_out_stb: got %0h expected 0", out_stb); end
      n_cmp++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL rst_occupancy: got %0d expected 0", occupancy); end
      n_cmp++; if (stall_cnt !== 4'd0) begin n_err++; $display("FAIL rst_stall_cnt: got %0d expected 0", stall_cnt); end
      rst = 1'b0;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rst_release_in_ready: got %0h expected 1", in_ready); end
   endtask

   task automatic test_single_beat();
      out_ready = 1'b1; in_valid = 1'b1; in_data = 16'h1234; in_stb = 2'b01;
      tick();
      in_valid = 1'b0; in_data = 16'h0; in_stb = 2'b00;
      #1;
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL beat_out_valid: got %0h expected 1", out_valid); end
      n_cmp++; if (out_data !== 16'h1234) begin n_err++; $display("FAIL beat_out_data: got %0h expected 1234", out_data); end
      n_cmp++; if (out_stb !== 2'b01) begin n_err++; $display("FAIL beat_out_stb: got %0h expected 1", out_stb); end
      n_cmp++; if (occupancy !== 2'd1) begin n_err++; $display("FAIL beat_occ1: got %0d expected 1", occupancy); end
      tick();
      n_cmp++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL beat_occ0: got %0d expected 0", occupancy); end
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL beat_drained_valid: got %0h expected 0", out_valid); end
      n_cmp++; if (out_stb !== 2'b00) begin n_err++; $display("FAIL beat_stb_cleared: got %0h expected 0", out_stb); end
   endtask

   task automatic test_back_to_back();
      logic [15:0] beats [4];
      beats[0] = 16'h1001; beats[1] = 16'h2002; beats[2] = 16'h3003; beats[3] = 16'h4004;
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         in_valid = 1'b1; in_data = beats[i]; in_stb = 2'b10;
         #1;
         n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL b2b_in_ready[%0d]: got %0h expected 1", i, in_ready); end
         tick();
         n_cmp++; if (out_data !== beats[i]) begin n_err++; $display("FAIL b2b_out_data[%0d]: got %0h expected %0h", i, out_data, beats[i]); end
         n_cmp++; if (occupancy !== 2'd1) begin n_err++; $display("FAIL b2b_occ[%0d]: got %0d expected 1", i, occupancy); end
         n_cmp++; if (out_stb !== 2'b10) begin n_err++; $display("FAIL b2b_out_stb[%0d]: got %0h expected 2", i, out_stb); end
      end
      in_valid = 1'b0;
      tick();
      n_cmp++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL b2b_drain: got %0d expected 0", occupancy); end
   endtask

   task automatic test_back_pressure();
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 16'h00AA; in_stb = 2'b01;
      tick();
      in_data = 16'h00BB; in_stb = 2'b10;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_in_ready_one: got %0h expected 1", in_ready); end
      tick();
      in_data = 16'h00CC; in_stb = 2'b11;
      #1;
      n_cmp++; if (occupancy !== 2'd2) begin n_err++; $display("FAIL bp_occ_full: got %0d expected 2", occupancy); end
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL bp_in_ready_full: got %0h expected 0", in_ready); end
      n_cmp++; if (out_data !== 16'h00AA) begin n_err++; $display("FAIL bp_head_a: got %0h expected aa", out_data); end
      n_cmp++; if (out_stb !== 2'b00) begin n_err++; $display("FAIL bp_stb_a_once: got %0h expected 0", out_stb); end
      tick();
      n_cmp++; if (occupancy !== 2'd2) begin n_err++; $display("FAIL bp_occ_hold: got %0d expected 2", occupancy); end
      out_ready = 1'b1;
      tick();
      n_cmp++; if (out_data !== 16'h00BB) begin n_err++; $display("FAIL bp_head_b: got %0h expected bb", out_data); end
      n_cmp++; if (out_stb !== 2'b10) begin n_err++; $display("FAIL bp_stb_b: got %0h expected 2", out_stb); end
      n_cmp++; if (occupancy !== 2'd1) begin n_err++; $display("FAIL bp_occ_one: got %0d expected 1", occupancy); end
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL bp_in_ready_back: got %0h expected 1", in_ready); end
      tick();
      in_valid = 1'b0;
      n_cmp++; if (out_data !== 16'h00CC) begin n_err++; $display("FAIL bp_head_c: got %0h expected cc", out_data); end
      n_cmp++; if (out_stb !== 2'b11) begin n_err++; $display("FAIL bp_stb_c: got %0h expected 3", out_stb); end
      tick();
      n_cmp++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL bp_drain: got %0d expected 0", occupancy); end
   endtask

   task automatic test_stall();
      out_ready = 1'b1;
      in_valid = 1'b1; in_data = 16'h0DDD; in_stb = 2'b11;
      tick();
      in_valid = 1'b0; in_stb = 2'b00; stall = 1'b1;
      #1;
      n_cmp++; if (out_stb !== 2'b11) begin n_err++; $display("FAIL stall_first_stb: got %0h expected 3", out_stb); end
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL stall_out_valid: got %0h expected 0", out_valid); end
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL stall_in_ready: got %0h expected 0", in_ready); end
      for (int i = 0; i < 5; i++) begin
         tick();
         n_cmp++; if (out_stb !== 2'b00) begin n_err++; $display("FAIL stall_stb_hold[%0d]: got %0h expected 0", i, out_stb); end
      end
      n_cmp++; if (stall_cnt !== 4'd5) begin n_err++; $display("FAIL stall_cnt5: got %0d expected 5", stall_cnt); end
      n_cmp++; if (occupancy !== 2'd1) begin n_err++; $display("FAIL stall_occ: got %0d expected 1", occupancy); end
      stall = 1'b0;
      #1;
      n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL stall_release_valid: got %0h expected 1", out_valid); end
      n_cmp++; if (out_data !== 16'h0DDD) begin n_err++; $display("FAIL stall_release_data: got %0h expected ddd", out_data); end
      n_cmp++; if (out_stb !== 2'b00) begin n_err++; $display("FAIL stall_release_stb: got %0h expected 0", out_stb); end
      tick();
      n_cmp++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL stall_delivered: got %0d expected 0", occupancy); end
      n_cmp++; if (stall_cnt !== 4'd5) begin n_err++; $display("FAIL stall_cnt_kept: got %0d expected 5", stall_cnt); end
   endtask

   task automatic test_flush();
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 16'h0E0E; in_stb = 2'b01;
      tick();
      in_data = 16'h0F0F;
      tick();
      n_cmp++; if (occupancy !== 2'd2) begin n_err++; $display("FAIL flush_prefill: got %0d expected 2", occupancy); end
      flush = 1'b1; in_data = 16'h0BAD;
      tick();
      flush = 1'b0; in_valid = 1'b0;
      n_cmp++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL flush_full_occ: got %0d expected 0", occupancy); end
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_full_valid: got %0h expected 0", out_valid); end
      n_cmp++; if (out_data !== 16'h0) begin n_err++; $display("FAIL flush_full_data: got %0h expected 0", out_data); end
      flush = 1'b1; in_valid = 1'b1; in_data = 16'hBEEF; out_ready = 1'b1;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL flush_in_ready: got %0h expected 1", in_ready); end
      tick();
      flush = 1'b0; in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL flush_dropped[%0d]: got valid %0h data %0h expected valid 0", i, out_valid, out_data); end
         tick();
      end
   endtask

   task automatic test_saturation();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_cmp++; if (stall_cnt !== 4'd0) begin n_err++; $display("FAIL sat_start: got %0d expected 0", stall_cnt); end
      stall = 1'b1;
      for (int i = 0; i < 14; i++) tick();
      n_cmp++; if (stall_cnt !== 4'd14) begin n_err++; $display("FAIL sat_cnt14: got %0d expected 14", stall_cnt); end
      for (int i = 0; i < 6; i++) tick();
      n_cmp++; if (stall_cnt !== 4'd15) begin n_err++; $display("FAIL sat_cnt15: got %0d expected 15", stall_cnt); end
      stall = 1'b0;
      tick();
      n_cmp++; if (stall_cnt !== 4'd15) begin n_err++; $display("FAIL sat_hold: got %0d expected 15", stall_cnt); end
   endtask

   task automatic test_rst_mid();
      out_ready = 1'b0;
      in_valid = 1'b1; in_data = 16'h0707; in_stb = 2'b11;
      tick();
      in_data = 16'h0808;
      tick();
      in_valid = 1'b0;
      n_cmp++; if (occupancy !== 2'd2) begin n_err++; $display("FAIL rstmid_prefill: got %0d expected 2", occupancy); end
      stall = 1'b1; rst = 1'b1;
      tick();
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rstmid_valid: got %0h expected 0", out_valid); end
      n_cmp++; if (out_data !== 16'h0) begin n_err++; $display("FAIL rstmid_data: got %0h expected 0", out_data); end
      n_cmp++; if (out_stb !== 2'b00) begin n_err++; $display("FAIL rstmid_stb: got %0h expected 0", out_stb); end
      n_cmp++; if (occupancy !== 2'd0) begin n_err++; $display("FAIL rstmid_occ: got %0d expected 0", occupancy); end
      n_cmp++; if (stall_cnt !== 4'd0) begin n_err++; $display("FAIL rstmid_cnt: got %0d expected 0", stall_cnt); end
      n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL rstmid_in_ready_rst: got %0h expected 0", in_ready); end
      rst = 1'b0; stall = 1'b0;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL rstmid_in_ready: got %0h expected 1", in_ready); end
   endtask

   initial begin
      test_reset();
      test_single_beat();
      test_back_to_back();
      test_back_pressure();
      test_stall();
      test_flush();
      test_saturation();
      test_rst_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
